corrige_hamming: RTL and testbench

//  Streaming Hamming(15,11) single-error-correcting decoder.
//  - Sits directly downstream of the 11->15 bit Hamming encoder, after the channel/storage path.
//  - Accepts 15-bit codewords on a valid/ready handshake and computes the 4-bit syndrome.
//  - Corrects any single flipped bit, then emits the 11 data bits with error flags and a saturating error counter.

---
 rtl/hamming_pkg.sv | 49 ++++
 rtl/calcula_sindrome.sv | 11 +
 rtl/corrige_hamming.sv | 126 ++++++++++++
 tb/tb_corrige_hamming.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(15,11) constants and helpers used by the decoder, the
// syndrome sub-module and the matching 11->15 bit encoder.
package hamming_pkg;

  localparam int HAM_N = 15;
  localparam int HAM_K = 11;
  localparam int HAM_R = 4;

  // Bit indices of the parity bits (Hamming positions 1, 2, 4 and 8).
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_P4 = 3;
  localparam int POS_P8 = 7;

  // Syndrome bit k is the XOR of every codeword bit whose Hamming position
  // (index + 1) has bit k set.
  function automatic logic [HAM_R-1:0] sindrome_f(input logic [HAM_N-1:0] cw);
    logic [HAM_R-1:0] s;
    logic [3:0]       pos;
    s = '0;
    for (int i = 0; i < HAM_N; i++) begin
      pos = 4'(i + 1);
      for (int k = 0; k < HAM_R; k++) begin
        if (pos[k]) s[k] = s[k] ^ cw[i];
      end
    end
    return s;
  endfunction

  // Data bits sit at every position that is not a power of two.
  function automatic logic [HAM_K-1:0] extrai_dados_f(input logic [HAM_N-1:0] cw);
    return {cw[14:8], cw[6:4], cw[2]};
  endfunction

  // Encoder: place the data, then set each parity bit so that its own
  // syndrome bit becomes zero (each parity bit feeds only one syndrome bit).
  function automatic logic [HAM_N-1:0] codifica_f(input logic [HAM_K-1:0] d);
    logic [HAM_N-1:0] cw;
    logic [HAM_R-1:0] s;
    cw = {d[10:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
    s  = sindrome_f(cw);
    cw[POS_P1] = s[0];
    cw[POS_P2] = s[1];
    cw[POS_P4] = s[2];
    cw[POS_P8] = s[3];
    return cw;
  endfunction

endpackage

// File: rtl/calcula_sindrome.sv
// Combinational syndrome of a 15-bit Hamming codeword.
module calcula_sindrome
  import hamming_pkg::*;
(
  input  logic [14:0] codeword,
  output logic [3:0]  sindrome
);

  assign sindrome = sindrome_f(codeword);

endmodule

// File: rtl/corrige_hamming.sv
// Two-stage streaming Hamming(15,11) single-error-correcting decoder with
// a saturating count of corrected words.
//
// Handshake: a word moves across a port on any rising edge where valid and
// ready are both high. A producer holds valid and its payload stable until
// that edge; ready never depends on in_valid. Here in_ready follows out_ready
// combinationally, and S2 outputs hold while out_ready is low.
module corrige_hamming
  import hamming_pkg::*;
#(
  parameter int CONT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [14:0]       entrada,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [10:0]       saida,
  output logic [3:0]        sindrome,
  output logic              erro_corr,
  output logic [CONT_W-1:0] erro_count,
  input  logic              clr_count
);

  logic              s1_valid_q, s1_valid_d;
  logic [14:0]       s1_cw_q, s1_cw_d;
  logic [3:0]        s1_sind_q, s1_sind_d;
  logic              out_valid_q, out_valid_d;
  logic [10:0]       saida_q, saida_d;
  logic [3:0]        sindrome_q, sindrome_d;
  logic              erro_corr_q, erro_corr_d;
  logic [CONT_W-1:0] erro_count_q, erro_count_d;

  logic        adv1, adv2;
  logic [3:0]  sind_in;
  logic [3:0]  flip_idx;
  logic [14:0] cw_corr;

  calcula_sindrome u_sindrome (
    .codeword (entrada),
    .sindrome (sind_in)
  );

  // Stage advance: a stage may load when it is empty or its contents leave.
  always_comb begin
    adv2     = !out_valid_q || out_ready;
    adv1     = !s1_valid_q || adv2;
    in_ready = adv1;
  end

  // S1: capture the codeword and its syndrome.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_sind_d  = s1_sind_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_cw_d   = entrada;
        s1_sind_d = sind_in;
      end
    end
  end

  // S2: flip the bit named by the syndrome and extract the data bits.
  always_comb begin
    flip_idx    = s1_sind_q - 4'd1;
    cw_corr     = s1_cw_q;
    if (s1_sind_q != 4'd0) cw_corr = s1_cw_q ^ (15'd1 << flip_idx);
    out_valid_d = out_valid_q;
    saida_d     = saida_q;
    sindrome_d  = sindrome_q;
    erro_corr_d = erro_corr_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        saida_d     = extrai_dados_f(cw_corr);
        sindrome_d  = s1_sind_q;
        erro_corr_d = (s1_sind_q != 4'd0);
      end
    end
  end

  // Corrected-word counter: clear wins, otherwise saturating increment.
  always_comb begin
    erro_count_d = erro_count_q;
    if (clr_count) begin
      erro_count_d = '0;
    end else if (out_valid_q && out_ready && erro_corr_q &&
                 (erro_count_q != {CONT_W{1'b1}})) begin
      erro_count_d = erro_count_q + CONT_W'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_cw_q      <= '0;
      s1_sind_q    <= '0;
      out_valid_q  <= 1'b0;
      saida_q      <= '0;
      sindrome_q   <= '0;
      erro_corr_q  <= 1'b0;
      erro_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_cw_q      <= s1_cw_d;
      s1_sind_q    <= s1_sind_d;
      out_valid_q  <= out_valid_d;
      saida_q      <= saida_d;
      sindrome_q   <= sindrome_d;
      erro_corr_q  <= erro_corr_d;
      erro_count_q <= erro_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign saida      = saida_q;
  assign sindrome   = sindrome_q;
  assign erro_corr  = erro_corr_q;
  assign erro_count = erro_count_q;

endmodule

// File: tb/tb_corrige_hamming.sv
// Directed bench for corrige_hamming: scoreboard of {erro_corr, sindrome,
// saida} filled on input transfers and checked on output transfers.
module tb_corrige_hamming;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] entrada = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [10:0] saida;
  logic [3:0]  sindrome;
  logic        erro_corr;
  logic [15:0] erro_count;
  logic        clr_count = 1'b0;

  logic        in4_valid = 1'b0;
  logic        in4_ready;
  logic [14:0] entrada4 = '0;
  logic        out4_valid;
  logic        out4_ready = 1'b1;
  logic [10:0] saida4;
  logic [3:0]  sindrome4;
  logic        erro_corr4;
  logic [3:0]  erro_count4;
  logic        clr_count4 = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  corrige_hamming u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .entrada(entrada), .out_valid(out_valid), .out_ready(out_ready),
    .saida(saida), .sindrome(sindrome), .erro_corr(erro_corr),
    .erro_count(erro_count), .clr_count(clr_count)
  );

  corrige_hamming #(.CONT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(in4_ready),
    .entrada(entrada4), .out_valid(out4_valid), .out_ready(out4_ready),
    .saida(saida4), .sindrome(sindrome4), .erro_corr(erro_corr4),
    .erro_count(erro_count4), .clr_count(clr_count4)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference encoder built directly from the position rules.
  function automatic logic [14:0] tb_enc(input logic [10:0] d);
    logic [14:0] cw;
    logic        par;
    int          j;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    for (int p = 0; p < 4; p++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if (((pos >> p) & 1) == 1) par = par ^ cw[pos-1];
      cw[(1 << p) - 1] = par;
    end
    return cw;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one word; push its expectation once the transfer is certain.
  task automatic send(input logic [14:0] cw, input logic [15:0] exp);
    int n;
    in_valid = 1'b1;
    entrada  = cw;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    else exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare each output transfer with the oldest expectation.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {16'd0, erro_corr, sindrome, saida}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", {16'd0, erro_corr, sindrome, saida}, {16'd0, e});
      end
    end
  end

  initial begin
    logic [10:0] d;
    logic [14:0] cw;
    logic [10:0] bp_d[5];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_saida", 32'(saida), 32'd0);
    check("rst_sindrome", 32'(sindrome), 32'd0);
    check("rst_erro_corr", 32'(erro_corr), 32'd0);
    check("rst_erro_count", 32'(erro_count), 32'd0);
    rst = 1'b0;
    step();

    // 1. Clean words, with latency check on the first
    send(15'h0007, {1'b0, 4'd0, 11'h001});
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    step();
    send(15'h7FFF, {1'b0, 4'd0, 11'h7FF});

    // 2. Single errors
    send(15'h0027, {1'b1, 4'd6, 11'h001});
    send(15'h3FFF, {1'b1, 4'd15, 11'h7FF});
    send(15'h0006, {1'b1, 4'd1, 11'h001});
    drain();
    step();
    check("count_after_t2", 32'(erro_count), 32'd3);

    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    check("count_cleared", 32'(erro_count), 32'd0);

    // 3. Encode / flip every bit / decode for 4 random words
    for (int w = 0; w < 4; w++) begin
      d  = 11'($urandom_range(0, 2047));
      cw = tb_enc(d);
      send(cw, {1'b0, 4'd0, d});
      for (int b = 0; b < 15; b++)
        send(cw ^ (15'd1 << b), {1'b1, 4'(b + 1), d});
      drain();
      step();
      check("count_per_word", 32'(erro_count), 32'(15 * (w + 1)));
    end

    // 4. Backpressure
    bp_d[0] = 11'h123; bp_d[1] = 11'h456; bp_d[2] = 11'h789;
    bp_d[3] = 11'h0AB; bp_d[4] = 11'h7CD;
    out_ready = 1'b0;
    send(tb_enc(bp_d[0]), {1'b0, 4'd0, bp_d[0]});
    send(tb_enc(bp_d[1]) ^ 15'h0010, {1'b1, 4'd5, bp_d[1]});
    in_valid = 1'b1;
    entrada  = tb_enc(bp_d[2]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_stable", {15'd0, out_valid, erro_corr, sindrome, saida},
            {15'd0, 1'b1, 1'b0, 4'd0, bp_d[0]});
    end
    step();
    out_ready = 1'b1;
    send(tb_enc(bp_d[2]), {1'b0, 4'd0, bp_d[2]});
    send(tb_enc(bp_d[3]) ^ 15'h4000, {1'b1, 4'd15, bp_d[3]});
    send(tb_enc(bp_d[4]), {1'b0, 4'd0, bp_d[4]});
    drain();

    // 5. Counter saturation and clear priority on the 4-bit instance
    in4_valid = 1'b1;
    entrada4  = 15'h0027;
    repeat (20) step();
    in4_valid = 1'b0;
    repeat (4) step();
    check("sat_count4", 32'(erro_count4), 32'd15);
    in4_valid = 1'b1;
    step();
    in4_valid = 1'b0;
    step();
    clr_count4 = 1'b1;
    @(negedge clk);
    check("clr_cycle_out4", 32'(out4_valid & erro_corr4), 32'd1);
    step();
    clr_count4 = 1'b0;
    check("clr_wins4", 32'(erro_count4), 32'd0);
    in4_valid = 1'b1;
    step();
    in4_valid = 1'b0;
    repeat (3) step();
    check("count4_after_clr", 32'(erro_count4), 32'd1);

    // 6. Reset with both stages full
    out_ready = 1'b0;
    send(15'h0027, {1'b1, 4'd6, 11'h001});
    send(15'h7FFF, {1'b0, 4'd0, 11'h7FF});
    check("pre_rst_count_nonzero", 32'(erro_count != 16'd0), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_count", 32'(erro_count), 32'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    step();
    send(15'h0006, {1'b1, 4'd1, 11'h001});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
